// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path.
// Holds the default sizes, the allocator FSM state encoding and the key-index type.
package synth_pkg;
    localparam int NUM_KEYS   = 13;
    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = 4;
    localparam int AGE_W      = 3;

    typedef enum logic [1:0] {IDLE, REL, PRS, DONE} state_t;

    typedef logic [KEY_W-1:0] key_t;
endpackage

// File: rtl/voice_alloc_if.sv
// Bus between the keyboard decoder side and the voice allocator.
//   key_mask   : held-key bitmask (asynchronous to the allocator clock)
//   voice_key  : key index per voice, voice v at [v*KEY_W +: KEY_W]
//   voice_gate : per-voice sounding flag
//   voice_trig : per-voice one-cycle retrigger pulse
//   last_key   : most recently assigned key
//   any_gate   : OR of voice_gate
//   busy       : allocator is scanning
// master = keyboard/oscillator side, slave = allocator.
interface voice_alloc_if #(
    parameter int NUM_KEYS   = synth_pkg::NUM_KEYS,
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int KEY_W      = synth_pkg::KEY_W
);
    logic [NUM_KEYS-1:0]         key_mask;
    logic [NUM_VOICES*KEY_W-1:0] voice_key;
    logic [NUM_VOICES-1:0]       voice_gate;
    logic [NUM_VOICES-1:0]       voice_trig;
    logic [KEY_W-1:0]            last_key;
    logic                        any_gate;
    logic                        busy;

    modport master (output key_mask,
                    input  voice_key, voice_gate, voice_trig, last_key, any_gate, busy);
    modport slave  (input  key_mask,
                    output voice_key, voice_gate, voice_trig, last_key, any_gate, busy);
endinterface

// File: rtl/voice_alloc_pick.sv
// Combinational voice selector.
//   gate   : per-voice sounding flags
//   ages   : per-voice age counters
//   target : lowest free voice, else the oldest gated voice (lowest index on ties)
//   steal  : 1 when no voice was free
module voice_pick #(
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int AGE_W      = synth_pkg::AGE_W,
    parameter int VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic [NUM_VOICES-1:0]            gate,
    input  logic [NUM_VOICES-1:0][AGE_W-1:0] ages,
    output logic [VIDX_W-1:0]                target,
    output logic                             steal
);
    import synth_pkg::*;

    logic [VIDX_W-1:0] free_idx, old_idx;
    logic [AGE_W-1:0]  old_age;
    logic              found;

    always_comb begin
        found    = 1'b0;
        free_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!gate[v] && !found) begin
                found    = 1'b1;
                free_idx = VIDX_W'(v);
            end
        end
    end

    // Only strictly greater ages replace the candidate, so ties keep the lower index.
    always_comb begin
        old_idx = '0;
        old_age = ages[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (ages[v] > old_age) begin
                old_age = ages[v];
                old_idx = VIDX_W'(v);
            end
        end
    end

    assign steal  = ~found;
    assign target = found ? free_idx : old_idx;
endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator.
//   clk, ar : clock, synchronous active-high reset
//   bus     : voice_alloc_if slave (key_mask in; voice_key/gate/trig, last_key,
//             any_gate, busy out)
// A snapshot of the synchronized mask is scanned key by key: first all
// releases, then all presses, so voices freed by this snapshot are reused
// before any steal.
module voice_alloc #(
    parameter int NUM_KEYS   = synth_pkg::NUM_KEYS,
    parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
    parameter int KEY_W      = synth_pkg::KEY_W,
    parameter int AGE_W      = synth_pkg::AGE_W
) (
    input  logic         clk,
    input  logic         ar,
    voice_alloc_if.slave bus
);
    import synth_pkg::*;

    localparam int               VIDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [KEY_W-1:0] LAST_IDX = KEY_W'(NUM_KEYS - 1);

    state_t                          state, state_nx;
    logic [NUM_KEYS-1:0]             sync1, sync_mask, snap, applied;
    logic [KEY_W-1:0]                idx, last_key;
    logic [NUM_VOICES-1:0][KEY_W-1:0] vkey;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age;
    logic [NUM_VOICES-1:0]           vgate, vtrig;
    logic [VIDX_W-1:0]               pick_tgt;
    logic                            pick_steal;
    logic                            idx_last, rel_step, prs_step, busy;

    assign idx_last = (idx == LAST_IDX);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (ar) state <= IDLE;
        else    state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sync_mask != applied) state_nx = REL;
            REL:     if (idx_last) state_nx = PRS;
            PRS:     if (idx_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state != IDLE);
        rel_step = (state == REL);
        prs_step = (state == PRS);
    end

    voice_pick #(.NUM_VOICES(NUM_VOICES), .AGE_W(AGE_W), .VIDX_W(VIDX_W)) u_pick (
        .gate   (vgate),
        .ages   (age),
        .target (pick_tgt),
        .steal  (pick_steal)
    );

    // A steal is only ever reported when every voice is sounding.
    always_comb assert (!pick_steal || (&vgate));

    always_ff @(posedge clk) begin
        if (ar) begin
            sync1     <= '0;
            sync_mask <= '0;
            snap      <= '0;
            applied   <= '0;
            idx       <= '0;
            vkey      <= '0;
            vgate     <= '0;
            vtrig     <= '0;
            age       <= '0;
            last_key  <= '0;
        end else begin
            sync1     <= bus.key_mask;
            sync_mask <= sync1;
            vtrig     <= '0;

            if (state == IDLE && sync_mask != applied) begin
                snap <= sync_mask;
                idx  <= '0;
            end

            if (rel_step) begin
                idx <= idx_last ? '0 : idx + 1'b1;
                // A stolen voice no longer carries the old key, so its release finds nothing.
                if (applied[idx] && !snap[idx]) begin
                    for (int v = 0; v < NUM_VOICES; v++)
                        if (vgate[v] && vkey[v] == idx) vgate[v] <= 1'b0;
                end
            end

            if (prs_step) begin
                idx <= idx_last ? '0 : idx + 1'b1;
                if (!applied[idx] && snap[idx]) begin
                    last_key <= idx;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (VIDX_W'(v) == pick_tgt) begin
                            vkey[v]  <= idx;
                            vgate[v] <= 1'b1;
                            age[v]   <= '0;
                            vtrig[v] <= 1'b1;
                        end else if (vgate[v] && age[v] != AGE_MAX) begin
                            age[v] <= age[v] + 1'b1;
                        end
                    end
                end
            end

            if (state == DONE) applied <= snap;
        end
    end

    assign bus.voice_key  = vkey;
    assign bus.voice_gate = vgate;
    assign bus.voice_trig = vtrig;
    assign bus.last_key   = last_key;
    assign bus.any_gate   = |vgate;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: a vector table of mask steps with expected
// voice state, plus hand sequences for reset with held keys and reset mid-scan.
module tb_voice_alloc;
    import synth_pkg::*;

    logic clk = 1'b0;
    logic ar  = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    voice_alloc_if #(.NUM_KEYS(13), .NUM_VOICES(4), .KEY_W(4)) bus ();

    voice_alloc #(.NUM_KEYS(13), .NUM_VOICES(4), .KEY_W(4), .AGE_W(3)) dut (
        .clk (clk),
        .ar  (ar),
        .bus (bus)
    );

    typedef struct {
        logic [12:0] mask;
        logic [3:0]  gate;
        logic [15:0] keys;
        int          ntrig;
        logic [3:0]  trig_or;
        key_t        last;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for one full scan (busy rises, then falls), collecting trig pulses.
    task automatic run_scan(output int ntrig, output logic [3:0] tor,
                            output bit overlap, output bit timeout);
        bit seen = 0;
        ntrig = 0; tor = '0; overlap = 0; timeout = 1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.voice_trig != '0) begin
                ntrig++;
                tor |= bus.voice_trig;
                if ($countones(bus.voice_trig) > 1) overlap = 1;
            end
            if (bus.busy) seen = 1;
            else if (seen) begin
                timeout = 0;
                break;
            end
        end
    endtask

    initial begin
        int         nt, lat;
        logic [3:0] tor;
        bit         ov, to;

        // voice_key packs v3..v0 as hex digits
        tv[0]  = '{13'h0000, 4'b0000, 16'h0004, 0, 4'b0000, 4'd4};
        tv[1]  = '{13'h0010, 4'b0001, 16'h0004, 1, 4'b0001, 4'd4};
        tv[2]  = '{13'h0000, 4'b0000, 16'h0004, 0, 4'b0000, 4'd4};
        tv[3]  = '{13'h0095, 4'b1111, 16'h7420, 4, 4'b1111, 4'd7};
        tv[4]  = '{13'h0294, 4'b1111, 16'h7429, 1, 4'b0001, 4'd9};
        tv[5]  = '{13'h0000, 4'b0000, 16'h7429, 0, 4'b0000, 4'd9};
        tv[6]  = '{13'h0001, 4'b0001, 16'h7420, 1, 4'b0001, 4'd0};
        tv[7]  = '{13'h0005, 4'b0011, 16'h7420, 1, 4'b0010, 4'd2};
        tv[8]  = '{13'h0015, 4'b0111, 16'h7420, 1, 4'b0100, 4'd4};
        tv[9]  = '{13'h0095, 4'b1111, 16'h7420, 1, 4'b1000, 4'd7};
        tv[10] = '{13'h0295, 4'b1111, 16'h7429, 1, 4'b0001, 4'd9};
        tv[11] = '{13'h0294, 4'b1111, 16'h7429, 0, 4'b0000, 4'd9};

        // Reset held with a key down
        bus.key_mask = 13'h0010;
        ar = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst gate", 32'(bus.voice_gate), 32'h0);
        chk("rst key",  32'(bus.voice_key),  32'h0);
        chk("rst last", 32'(bus.last_key),   32'h0);
        chk("rst busy", 32'(bus.busy),       32'h0);
        chk("rst trig", 32'(bus.voice_trig), 32'h0);

        ar = 1'b0;
        nt = 0; lat = 0; tor = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.voice_trig != '0) begin
                nt++;
                tor |= bus.voice_trig;
                if (lat == 0) lat = c;
            end
        end
        chk("rst realloc ntrig", 32'(nt), 32'd1);
        chk("rst realloc trig",  32'(tor), 32'h1);
        chk("rst realloc latency<=29", 32'(lat > 0 && lat <= 29), 32'd1);
        chk("rst realloc gate",  32'(bus.voice_gate), 32'h1);
        chk("rst realloc key0",  32'(bus.voice_key[3:0]), 32'h4);
        chk("rst realloc last",  32'(bus.last_key), 32'h4);

        // Table of mask steps
        for (int i = 0; i < 12; i++) begin
            bus.key_mask = tv[i].mask;
            run_scan(nt, tor, ov, to);
            chk($sformatf("v%0d timeout", i),  32'(to), 32'd0);
            chk($sformatf("v%0d gate", i),     32'(bus.voice_gate), 32'(tv[i].gate));
            chk($sformatf("v%0d keys", i),     32'(bus.voice_key), 32'(tv[i].keys));
            chk($sformatf("v%0d ntrig", i),    32'(nt), 32'(tv[i].ntrig));
            chk($sformatf("v%0d trig_or", i),  32'(tor), 32'(tv[i].trig_or));
            chk($sformatf("v%0d overlap", i),  32'(ov), 32'd0);
            chk($sformatf("v%0d last", i),     32'(bus.last_key), 32'(tv[i].last));
            chk($sformatf("v%0d any_gate", i), 32'(bus.any_gate), 32'(|tv[i].gate));
        end

        // Reset in the middle of the press pass
        bus.key_mask = 13'h0000;
        repeat (20) @(negedge clk);
        chk("mid busy before rst", 32'(bus.busy), 32'd1);
        ar = 1'b1;
        @(negedge clk);
        chk("mid rst gate", 32'(bus.voice_gate), 32'h0);
        chk("mid rst key",  32'(bus.voice_key),  32'h0);
        chk("mid rst last", 32'(bus.last_key),   32'h0);
        chk("mid rst busy", 32'(bus.busy),       32'h0);
        chk("mid rst trig", 32'(bus.voice_trig), 32'h0);
        chk("mid rst any",  32'(bus.any_gate),   32'h0);
        ar = 1'b0;
        bus.key_mask = 13'h0001;
        run_scan(nt, tor, ov, to);
        chk("mid post timeout", 32'(to), 32'd0);
        chk("mid post gate",    32'(bus.voice_gate), 32'h1);
        chk("mid post key0",    32'(bus.voice_key[3:0]), 32'h0);
        chk("mid post ntrig",   32'(nt), 32'd1);
        chk("mid post trig",    32'(tor), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Polyphonic voice allocator between the PS/2 keyboard decoder and the wavetable oscillator bank.
- Takes the held-key bitmask (piano keys only) and assigns each newly pressed key to one of NUM_VOICES oscillator voices.
- Frees a voice when its key is released. When all voices are busy, steals the oldest voice.
- Outputs a per-voice key index, gate and one-cycle retrigger pulse.

Parameters:
- NUM_KEYS, 13, number of piano key bits consumed (bitmask indices 0..NUM_KEYS-1)
- NUM_VOICES, 4, number of oscillator voices shared
- KEY_W, 4, width of a key index
- AGE_W, 3, per-voice age counter width; must be >= clog2(NUM_VOICES)+1

Ports:
- clk  in  1  system clock
- ar  in  1  reset; synchronous, active-high
- key_mask  in  NUM_KEYS  held-key bitmask from the keyboard decoder (ps2 clock domain, asynchronous to clk)
- voice_key  out  NUM_VOICES*KEY_W  key index per voice; voice v occupies bits [v*KEY_W +: KEY_W]
- voice_gate  out  NUM_VOICES  1 = voice sounding
- voice_trig  out  NUM_VOICES  one-clk pulse when a voice gets a new key (including on steal)
- last_key  out  KEY_W  most recently assigned key (mono fallback)
- any_gate  out  1  |voice_gate
- busy  out  1  allocator is scanning (state != IDLE)

Behaviour:
- Reset (ar=1 at a clk edge), applies mid-scan as well:
  - state=IDLE; sync flops, snap and applied all 0.
  - All voice_key, voice_gate, voice_trig, ages and last_key are 0; busy=0.
- Input sync: key_mask passes through a 2-flop synchronizer, giving sync_mask. No other logic reads key_mask directly.
- FSM, states IDLE, REL, PRS, DONE:
  - IDLE: if sync_mask != applied, then snap<=sync_mask, idx<=0, go to REL. Otherwise stay in IDLE.
  - REL: one key per cycle, idx 0..NUM_KEYS-1. If applied[idx]=1 and snap[idx]=0, every voice with gate=1 and key==idx gets gate<=0. If no voice holds idx, no-op. After idx=NUM_KEYS-1, set idx<=0 and go to PRS.
  - PRS: one key per cycle. If applied[idx]=0 and snap[idx]=1, allocate idx as described below. After NUM_KEYS-1, go to DONE.
  - DONE: applied<=snap; go to IDLE.
- Releases are always processed before presses from the same snapshot, so a freed voice is reused before any steal happens.
- Allocation for key k:
  - Target is the lowest-index voice with gate=0. If there is none, target is the gated voice with maximum age; ties go to the lowest index.
  - Target gets key<=k, gate<=1, age<=0, and voice_trig[target]=1 for exactly one cycle (the cycle after the PRS step). Also last_key<=k.
  - Every other voice with gate=1 gets age<=age+1, saturating at 2^AGE_W-1.
- At most one allocation per cycle, so voice_trig is one-hot or zero.
- Release does not change age. A stolen voice keeps gate=1, and its old key becomes unowned. A later release of that old key is a no-op.
- Mask changes during a scan are ignored until the next IDLE compare.
- Latency from a key_mask change to voice_gate/voice_trig: at most 2 (sync) + 1 (IDLE) + 2*NUM_KEYS = 29 clk at default.
- Bitmask indices above NUM_KEYS-1 are not connected; +/- select is handled elsewhere.
- After reset with keys still held: sync_mask != applied=0, so held keys are re-allocated as fresh presses.

Decomposition:
- Shared package synth_pkg holds:
  - NUM_KEYS, KEY_W, AGE_W defaults;
  - FSM state encoding (IDLE, REL, PRS, DONE);
  - the key-index type.
- One sub-module, voice_pick. It is purely combinational: it takes voice_gate and the packed ages, and returns a target index plus a steal flag, implementing the free-first / oldest-steal / lowest-index tie rule.
- The FSM, ages and outputs stay in voice_alloc.

Test Plan:
- Reset: hold ar=1 for 3 clk with key_mask=0x0010 -> voice_gate=0, voice_key=0, last_key=0, busy=0. Release ar -> within 29 clk voice0 key=4, gate=1, trig[0] pulses once.
- Single press/release: key_mask 0x0000->0x0010 -> voice0 key=4, gate=1, one trig[0], last_key=4. Then 0x0000 -> voice_gate=0000 with no trig, any_gate=0.
- Chord: key_mask 0x0000->0x0095 in one step (keys 0,2,4,7) -> voices 0..3 get keys 0,2,4,7 in that order. Four single-cycle trigs on trig[0]..trig[3] in successive cycles, never overlapping.
- Steal: press 0, 2, 4, 7 sequentially, waiting for busy=0 between each, then add key 9 -> voice0 (oldest) key=9, gate stays 1, trig[0]. Then release key 0 -> no change to any voice.
- Release+press in one snapshot: from {0,2,4,7} held, change directly to {2,4,7,9} -> voice0 freed in REL and reassigned to key 9 in PRS. Voices 1..3 unchanged, exactly one trig.
- Reset mid-scan: assert ar for 1 clk while busy=1 in PRS -> next cycle all outputs 0, busy=0. Then with 0x0001 held -> voice0 key=0 gate=1 within 29 clk.
